// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the byte FIFO and serialises each byte as a UART frame.
// Frame layout: start (0), 8 data bits LSB-first, [even parity], stop (1).
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert the even-parity bit.
// Every bit holds txd for CLKS_PER_BIT clocks. All outputs are registered.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       fifo_ready,
   input  logic [7:0] fifo_data,
   output logic       fifo_read,
   output logic       txd,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } state_t;
`endif

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             txd_reg, txd_next;
   logic             busy_reg, busy_next;
   logic             fifo_read_reg, fifo_read_next;
   logic             baud_last;

   assign baud_last = (baud_cnt_reg == CNT_LAST);

   // State and output registers; clrn abandons any frame in flight.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_reg     <= ST_IDLE;
         baud_cnt_reg  <= '0;
         bit_idx_reg   <= 3'd0;
         shift_reg     <= 8'd0;
         txd_reg       <= 1'b1;
         busy_reg      <= 1'b0;
         fifo_read_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         baud_cnt_reg  <= baud_cnt_next;
         bit_idx_reg   <= bit_idx_next;
         shift_reg     <= shift_next;
         txd_reg       <= txd_next;
         busy_reg      <= busy_next;
         fifo_read_reg <= fifo_read_next;
      end
   end

   // Next-state logic: latch on fifo_ready in IDLE, then step one bit per baud period.
   always_comb begin
      state_next     = state_reg;
      baud_cnt_next  = baud_cnt_reg;
      bit_idx_next   = bit_idx_reg;
      shift_next     = shift_reg;
      txd_next       = txd_reg;
      busy_next      = busy_reg;
      fifo_read_next = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            txd_next      = 1'b1;
            busy_next     = 1'b0;
            baud_cnt_next = '0;
            bit_idx_next  = 3'd0;
            if (fifo_ready) begin
               // The byte is captured here only; later fifo_data changes are ignored.
               shift_next     = fifo_data;
               fifo_read_next = 1'b1;
               txd_next       = 1'b0;
               busy_next      = 1'b1;
               state_next     = ST_START;
            end
         end

         ST_START: begin
            if (baud_last) begin
               baud_cnt_next = '0;
               bit_idx_next  = 3'd0;
               txd_next      = shift_reg[0];
               state_next    = ST_DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end

         ST_DATA: begin
            if (baud_last) begin
               baud_cnt_next = '0;
               if (bit_idx_reg == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  txd_next   = ^shift_reg;
                  state_next = ST_PARITY;
`else
                  txd_next   = 1'b1;
                  state_next = ST_STOP;
`endif
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  txd_next     = shift_reg[bit_idx_reg + 3'd1];
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end

`ifdef FIFO_UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_last) begin
               baud_cnt_next = '0;
               txd_next      = 1'b1;
               state_next    = ST_STOP;
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end
`endif

         ST_STOP: begin
            if (baud_last) begin
               baud_cnt_next = '0;
               txd_next      = 1'b1;
               busy_next     = 1'b0;
               state_next    = ST_IDLE;
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end

         default: begin
            state_next    = ST_IDLE;
            baud_cnt_next = '0;
            bit_idx_next  = 3'd0;
            txd_next      = 1'b1;
            busy_next     = 1'b0;
         end
      endcase
   end

   assign fifo_read = fifo_read_reg;
   assign txd       = txd_reg;
   assign busy      = busy_reg;

endmodule
